mult16_seq: RTL and testbench

//  Sequential 16x16 unsigned shift-and-add multiplier; 32-bit product.

---
 rtl/mult16_seq_pkg.sv | 21 ++
 rtl/mult16_seq_adder16.sv | 17 +
 rtl/mult16_seq.sv | 105 ++++++++++
 tb/tb_mult16_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mult16_seq_pkg.sv
// Shared definitions for the sequential 16x16 shift-and-add multiplier.
//   WIDTH     : operand width, tied to the 16-bit adder used for partial sums
//   CNT_W     : iteration counter width, holds 0..WIDTH
//   PROD_W    : product width (2*WIDTH)
//   state_t   : control FSM states IDLE -> CALC -> DONE -> IDLE
package mult16_seq_pkg;

  localparam int WIDTH  = 16;
  localparam int CNT_W  = 5;
  localparam int PROD_W = 2 * WIDTH;

  // Counter value seen on the final CALC edge (iterations 0..WIDTH-1).
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult16_seq_adder16.sv
// 16-bit ripple adder with carry in/out; produces one partial-product sum per
// clock for the multiplier.
//   a, b  : 16-bit addends
//   cin   : carry in
//   sum   : 16-bit sum
//   cout  : carry out
module adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'h0000, cin};

endmodule

// File: rtl/mult16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier with a 32-bit product.
// One conditional add of the multiplicand into the upper accumulator half per
// clock, followed by a right shift; 16 iterations per multiply.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   start   : request, only honoured in IDLE
//   a, b    : multiplicand / multiplier, captured on an accepted start
//   busy    : high while iterating
//   done    : one-cycle pulse when product is updated
//   product : result register, held until the next result is written
module mult16_seq
  import mult16_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mcand;
  logic [PROD_W-1:0]  acc;
  logic [PROD_W-1:0]  acc_nxt;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH-1:0]   part_s;
  logic               part_c;

  adder16 u_add (
    .a    (acc[PROD_W-1:WIDTH]),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Multiplier LSB selects add-or-pass; the adder carry re-enters at the top
  // of the shifted accumulator so the 33-bit intermediate never overflows.
  always_comb begin
    part_c = 1'b0;
    part_s = acc[PROD_W-1:WIDTH];
    if (acc[0]) begin
      part_c = add_cout;
      part_s = add_sum;
    end
    acc_nxt = {part_c, part_s, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CALC;
      ST_CALC: if (count == LAST_ITER) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      mcand   <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            count <= '0;
          end
        end
        ST_CALC: begin
          acc   <= acc_nxt;
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            product <= acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Both flags decode the state register, so they are glitch-free and
  // mutually exclusive.
  assign busy = (state == ST_CALC);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mult16_seq.sv
// Testbench for mult16_seq: table-driven directed vectors, randomized
// operands against an arithmetic reference, and hand-written sequences for
// start-while-busy, mid-calculation reset and back-to-back operation.
module tb_mult16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_checks;
  int n_fail;
  int done_total;
  int overlap;
  int cyc;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[6];

  mult16_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) done_total++;
    if (done && busy) overlap++;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h (%0d), required 0x%0h (%0d)", nm, act, act, exp, exp);
    end
  endtask

  // Called at a sample point (#1 after an edge); steps until done or limit.
  task automatic wait_done(input string nm, input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv,
                        input logic [31:0] exp, input string nm);
    logic [31:0] old_p;
    int busy_cnt;
    int i;
    bit seen;
    @(negedge clk);
    a = ta; b = tbv; start = 1'b1;
    old_p = product;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    check({nm, " prod_hold"}, product, old_p);
    busy_cnt = 0; i = 0; seen = 1'b0;
    while (!seen && i < 40) begin
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        i++;
      end
    end
    check({nm, " latency"}, 32'(i + 1), 32'd17);
    check({nm, " busy_cycles"}, 32'(busy_cnt), 32'd16);
    check({nm, " product"}, product, exp);
    @(posedge clk); #1;
    check({nm, " done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    int last;
    logic [15:0] ra;
    logic [15:0] rb;

    n_checks = 0; n_fail = 0; done_total = 0; overlap = 0; cyc = 0;
    vecs[0] = '{16'd3,    16'd5,    32'd15};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h1234, 16'h0000, 32'h0};
    vecs[3] = '{16'h0000, 16'hABCD, 32'h0};
    vecs[4] = '{16'h8000, 16'h0002, 32'h00010000};
    vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset product", product, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run_op(vecs[k].a, vecs[k].b, vecs[k].p, $sformatf("vec%0d", k));
    end

    for (int k = 0; k < 20; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, ref_mul(ra, rb), $sformatf("rand%0d", k));
    end

    // Start pulsed mid-calculation with new operands must be ignored.
    @(negedge clk);
    a = 16'd2; b = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_total;
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = 16'd100; b = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    #6;
    wait_done("busy_start", 40, n);
    check("busy_start product", product, ref_mul(16'd2, 16'd3));
    repeat (20) @(posedge clk);
    #1;
    check("busy_start done_count", 32'(done_total - d0), 32'd1);

    // Reset in the middle of a calculation.
    @(negedge clk);
    a = 16'd7; b = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst product", product, 32'd0);
    d0 = done_total;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("midrst no_done", 32'(done_total - d0), 32'd0);
    check("midrst product_after", product, 32'd0);
    run_op(16'd7, 16'd9, ref_mul(16'd7, 16'd9), "after_rst");

    // Start held high: one result every 18 cycles.
    @(negedge clk);
    a = 16'd100; b = 16'd300; start = 1'b1;
    last = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 1) #6;
      wait_done($sformatf("held%0d", k), 40, n);
      check($sformatf("held%0d product", k), product,
            ref_mul(16'(100 * k), 16'(300 * k)));
      if (k > 1) check($sformatf("held%0d spacing", k), 32'(cyc - last), 32'd18);
      last = cyc;
      if (k < 4) begin
        a = 16'(100 * (k + 1));
        b = 16'(300 * (k + 1));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end

    check("busy_done_overlap", 32'(overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
